// File: rtl/shape_processor_arbiter.sv
// Two-requester round-robin front end for the shape processor; one transaction in flight at a time.
// Grant is combinational in IDLE; strobe one cycle later, done RESP_LATENCY cycles after the strobe; requesters wait on gnt.
module shape_processor_arbiter #(
    parameter int RESP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic        r0_write,
    input  logic        r1_write,
    input  logic [31:0] r0_wdata,
    input  logic [31:0] r1_wdata,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_done,
    output logic        r1_done,
    output logic [31:0] r0_rdata,
    output logic [31:0] r1_rdata,
    output logic        r0_err,
    output logic        r1_err,
    output logic        write,
    output logic [31:0] write_data,
    output logic        read,
    input  logic [31:0] read_data,
    input  logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int WAIT_CYC = (RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0;

    state_t      state_q;
    logic        prio_q;
    logic        win_q;
    logic        wr_q;
    logic [1:0]  cnt_q;
    logic        write_q;
    logic [31:0] write_data_q;
    logic        read_q;
    logic [31:0] r0_rdata_q;
    logic [31:0] r1_rdata_q;
    logic        r0_err_q;
    logic        r1_err_q;

    logic        pick_r1;
    logic        any_req;
    logic        grant;
    logic        sel_write;
    logic [31:0] sel_wdata;
    logic        resp;
    logic [31:0] resp_rdata;

    assign pick_r1   = r1_req & (~r0_req | prio_q);
    assign any_req   = r0_req | r1_req;
    // Gating with rst_n keeps gnt low while reset is held even with req asserted.
    assign grant     = (state_q == IDLE) & any_req & rst_n;
    assign sel_write = pick_r1 ? r1_write : r0_write;
    assign sel_wdata = pick_r1 ? r1_wdata : r0_wdata;
    assign resp      = (state_q == RESP);
    assign resp_rdata = wr_q ? 32'd0 : read_data;

    assign r0_gnt     = grant & ~pick_r1;
    assign r1_gnt     = grant & pick_r1;
    assign r0_done    = resp & ~win_q;
    assign r1_done    = resp & win_q;
    assign r0_rdata   = r0_done ? resp_rdata : r0_rdata_q;
    assign r1_rdata   = r1_done ? resp_rdata : r1_rdata_q;
    assign r0_err     = r0_done ? error : r0_err_q;
    assign r1_err     = r1_done ? error : r1_err_q;
    assign write      = write_q;
    assign write_data = write_data_q;
    assign read       = read_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            win_q        <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= 2'd0;
            write_q      <= 1'b0;
            write_data_q <= 32'd0;
            read_q       <= 1'b0;
            r0_rdata_q   <= 32'd0;
            r1_rdata_q   <= 32'd0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q        <= pick_r1;
                        prio_q       <= ~pick_r1;
                        wr_q         <= sel_write;
                        write_q      <= sel_write;
                        write_data_q <= sel_write ? sel_wdata : 32'd0;
                        read_q       <= ~sel_write;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    write_q      <= 1'b0;
                    write_data_q <= 32'd0;
                    read_q       <= 1'b0;
                    if (RESP_LATENCY == 1) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= 2'(WAIT_CYC);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (win_q) begin
                        r1_rdata_q <= resp_rdata;
                        r1_err_q   <= error;
                    end else begin
                        r0_rdata_q <= resp_rdata;
                        r0_err_q   <= error;
                    end
                    wr_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_processor_arbiter.sv
// Directed bench: latency-1 instance for protocol checks, latency-3 instance for wait-state timing.
module tb_shape_processor_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic        r0_write = 1'b0, r1_write = 1'b0;
    logic [31:0] r0_wdata = 32'd0, r1_wdata = 32'd0;
    logic [31:0] read_data = 32'd0;
    logic        error = 1'b0;

    logic        r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
    logic [31:0] r0_rdata, r1_rdata, write_data;
    logic        write, read, busy;

    logic        r0_gnt3, r1_gnt3, r0_done3, r1_done3, r0_err3, r1_err3;
    logic [31:0] r0_rdata3, r1_rdata3, write_data3;
    logic        write3, read3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shape_processor_arbiter #(.RESP_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req), .r0_write(r0_write), .r1_write(r1_write),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .r0_err(r0_err), .r1_err(r1_err),
        .write(write), .write_data(write_data), .read(read),
        .read_data(read_data), .error(error), .busy(busy)
    );

    shape_processor_arbiter #(.RESP_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req), .r0_write(r0_write), .r1_write(r1_write),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt3), .r1_gnt(r1_gnt3), .r0_done(r0_done3), .r1_done(r1_done3),
        .r0_rdata(r0_rdata3), .r1_rdata(r1_rdata3), .r0_err(r0_err3), .r1_err(r1_err3),
        .write(write3), .write_data(write_data3), .read(read3),
        .read_data(read_data), .error(error), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0; r0_write = 1'b0; r1_write = 1'b0;
        r0_wdata = 32'd0; r1_wdata = 32'd0; read_data = 32'd0; error = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; r0_write = 1'b1; r0_wdata = 32'hFFFF_FFFF;
        tick(); tick(); #1;
        checks++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, write, read, busy} !== 9'd0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, write, read, busy});
        end
        checks++;
        if ({r0_rdata, r1_rdata, write_data} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {r0_rdata, r1_rdata, write_data});
        end
        rst_n = 1'b1; #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            errors++; $display("FAIL release_gnt got %b exp 10", {r0_gnt, r1_gnt});
        end
        tick();
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if ({write, read, busy, write_data} !== {3'b101, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL release_issue got %b %h exp 101 ffffffff", {write, read, busy}, write_data);
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_single_write();
        do_reset();
        r0_req = 1'b1; r0_write = 1'b1; r0_wdata = 32'h0002_0003; #1;
        checks++;
        if ({r0_gnt, r1_gnt, busy} !== 3'b100) begin
            errors++; $display("FAIL wr_gnt got %b exp 100", {r0_gnt, r1_gnt, busy});
        end
        tick();
        r0_req = 1'b0; r0_wdata = 32'hAAAA_AAAA; #1;
        checks++;
        if ({write, read, busy, r0_gnt} !== 4'b1010 || write_data !== 32'h0002_0003) begin
            errors++; $display("FAIL wr_issue got %b %h exp 1010 00020003", {write, read, busy, r0_gnt}, write_data);
        end
        tick();
        read_data = 32'h1234_5678;
        #1;
        checks++;
        if ({r0_done, r0_err, r1_done, write} !== 4'b1000 || r0_rdata !== 32'd0) begin
            errors++; $display("FAIL wr_done got %b %h exp 1000 0", {r0_done, r0_err, r1_done, write}, r0_rdata);
        end
        tick();
        checks++;
        if ({r0_done, busy, write_data} !== 34'd0) begin
            errors++; $display("FAIL wr_after got %b %h exp 0", {r0_done, busy}, write_data);
        end
    endtask

    task automatic test_read_r1();
        do_reset();
        r1_req = 1'b1; r1_write = 1'b0; #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            errors++; $display("FAIL rd_gnt got %b exp 01", {r0_gnt, r1_gnt});
        end
        tick();
        r1_req = 1'b0; read_data = 32'hDEAD_BEEF;
        r0_req = 1'b1; r0_write = 1'b1; r0_wdata = 32'h5555_5555;
        #1;
        checks++;
        if ({read, write, write_data} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL rd_issue got %b %h exp 10 0", {read, write}, write_data);
        end
        tick();
        r0_req = 1'b0;
        read_data = 32'h0001_0005; #1;
        checks++;
        if (r1_done !== 1'b1 || r1_rdata !== 32'h0001_0005) begin
            errors++; $display("FAIL rd_done got %b %h exp 1 00010005", r1_done, r1_rdata);
        end
        checks++;
        if ({r0_gnt, r0_done, r0_err, r0_rdata} !== 35'd0) begin
            errors++; $display("FAIL rd_r0_quiet got %b %h exp 0", {r0_gnt, r0_done, r0_err}, r0_rdata);
        end
        tick();
        read_data = 32'd0; #1;
        checks++;
        if (r1_done !== 1'b0 || r1_rdata !== 32'h0001_0005) begin
            errors++; $display("FAIL rd_hold got %b %h exp 0 00010005", r1_done, r1_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({r0_gnt, busy, write} !== 3'b000) begin
                errors++; $display("FAIL ignored_req got %b exp 000", {r0_gnt, busy, write});
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int who [4];
        int at [4];
        int n = 0;
        do_reset();
        r0_req = 1'b1; r1_req = 1'b1; r0_write = 1'b0; r1_write = 1'b0; #1;
        for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
            if (r0_gnt && r1_gnt) begin
                checks++; errors++; $display("FAIL rr_both_gnt got 11 exp one-hot");
            end
            if (write && read) begin
                checks++; errors++; $display("FAIL rr_strobes got 11 exp one-hot");
            end
            if (r0_gnt || r1_gnt) begin
                who[n] = r1_gnt ? 1 : 0;
                at[n] = cyc;
                n++;
            end
            tick();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL rr_count got %0d exp 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (who[i] !== (i % 2)) begin
                    errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, who[i], i % 2);
                end
                if (i > 0) begin
                    checks++;
                    if (at[i] - at[i-1] !== 3) begin
                        errors++; $display("FAIL rr_gap[%0d] got %0d exp 3", i, at[i] - at[i-1]);
                    end
                end
            end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_error_hold();
        do_reset();
        r1_req = 1'b1; r1_write = 1'b1; r1_wdata = 32'h0003_001F;
        tick();
        r1_req = 1'b0;
        tick();
        error = 1'b1; read_data = 32'h0000_0055; #1;
        checks++;
        if ({r1_done, r1_err} !== 2'b11 || r1_rdata !== 32'd0) begin
            errors++; $display("FAIL err_done got %b %h exp 11 0", {r1_done, r1_err}, r1_rdata);
        end
        tick();
        error = 1'b0; #1;
        checks++;
        if ({r1_done, r1_err, r0_err} !== 3'b010) begin
            errors++; $display("FAIL err_hold got %b exp 010", {r1_done, r1_err, r0_err});
        end
        tick();
        r1_req = 1'b1; r1_write = 1'b0;
        tick();
        r1_req = 1'b0;
        tick();
        read_data = 32'h0000_0077; #1;
        checks++;
        if ({r1_done, r1_err} !== 2'b10 || r1_rdata !== 32'h0000_0077) begin
            errors++; $display("FAIL err_clear got %b %h exp 10 00000077", {r1_done, r1_err}, r1_rdata);
        end
        tick(); tick();
    endtask

    task automatic test_latency3();
        do_reset();
        r0_req = 1'b1; r0_write = 1'b0; #1;
        checks++;
        if ({r0_gnt3, busy3} !== 2'b10) begin
            errors++; $display("FAIL l3_gnt got %b exp 10", {r0_gnt3, busy3});
        end
        tick();
        r0_req = 1'b0; #1;
        checks++;
        if ({read3, write3, busy3, r0_done3} !== 4'b1010) begin
            errors++; $display("FAIL l3_issue got %b exp 1010", {read3, write3, busy3, r0_done3});
        end
        for (int i = 2; i <= 3; i++) begin
            tick();
            checks++;
            if ({read3, busy3, r0_done3} !== 3'b010) begin
                errors++; $display("FAIL l3_wait_T%0d got %b exp 010", i, {read3, busy3, r0_done3});
            end
        end
        tick();
        read_data = 32'h1234_5678; #1;
        checks++;
        if ({r0_done3, busy3} !== 2'b11 || r0_rdata3 !== 32'h1234_5678) begin
            errors++; $display("FAIL l3_done got %b %h exp 11 12345678", {r0_done3, busy3}, r0_rdata3);
        end
        tick();
        read_data = 32'd0; #1;
        checks++;
        if ({r0_done3, busy3} !== 2'b00) begin
            errors++; $display("FAIL l3_idle got %b exp 00", {r0_done3, busy3});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        r0_req = 1'b1; r0_write = 1'b1; r0_wdata = 32'h0001_0002;
        tick();
        r0_req = 1'b0;
        rst_n = 1'b0; #1;
        checks++;
        if ({write, read, busy, r0_gnt, r1_gnt, r0_done, write_data} !== 38'd0) begin
            errors++; $display("FAIL mid_abort got %b %h exp 0", {write, read, busy, r0_gnt, r1_gnt, r0_done}, write_data);
        end
        tick(); tick();
        checks++;
        if ({write, r0_done, r1_done, busy} !== 4'd0) begin
            errors++; $display("FAIL mid_quiet got %b exp 0", {write, r0_done, r1_done, busy});
        end
        r0_req = 1'b1; r1_req = 1'b1; r0_write = 1'b0; r1_write = 1'b0;
        rst_n = 1'b1; #1;
        checks++;
        if ({r0_gnt, r1_gnt} !== 2'b10) begin
            errors++; $display("FAIL mid_prio got %b exp 10", {r0_gnt, r1_gnt});
        end
        tick();
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if ({write, read, write_data} !== {2'b01, 32'd0}) begin
            errors++; $display("FAIL mid_no_replay got %b %h exp 01 0", {write, read}, write_data);
        end
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_r1();
        test_round_robin();
        test_error_hold();
        test_latency3();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
